// File: rtl/mem_resp_ctrl_if.sv
// Request/grant/read-response bundle between requester channels and mem_resp_ctrl.
interface mem_resp_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int NUM_CH     = 2
);
  logic [NUM_CH-1:0]            ch_rd_req;
  logic [NUM_CH-1:0]            ch_wr_req;
  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_wr_data;
  logic [NUM_CH-1:0]            ch_gnt;
  logic [NUM_CH-1:0]            rd_valid;
  logic [DATA_WIDTH-1:0]        rd_data;
  logic                         init_done;

  modport master (
    output ch_rd_req, ch_wr_req, ch_addr, ch_wr_data,
    input  ch_gnt, rd_valid, rd_data, init_done
  );

  modport slave (
    input  ch_rd_req, ch_wr_req, ch_addr, ch_wr_data,
    output ch_gnt, rd_valid, rd_data, init_done
  );
endinterface

// File: rtl/mem_resp_ctrl.sv
// Multi-channel round-robin memory controller: zero-fills memory after reset,
// then serves one read or write per cycle with a fixed-latency tagged read pipeline.
module mem_resp_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int NUM_CH     = 2,
  parameter int RD_LATENCY = 2,
  parameter int MEM_DEPTH  = 2**ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_resp_ctrl_if.slave  bus
);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      rr_q, rr_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [RD_LATENCY-1:0] pv_q, pv_d;
  logic [PTR_W-1:0]      ptag_q [RD_LATENCY];
  logic [PTR_W-1:0]      ptag_d [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pdata_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pdata_d [RD_LATENCY];

  logic [NUM_CH-1:0]     elig;
  logic [NUM_CH-1:0]     gnt;
  logic                  gnt_any;
  logic [PTR_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      gnt_widx;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic                  do_wr, do_rd;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] w;
    w = 32'(a) % 32'(MEM_DEPTH);
    return w[IDX_W-1:0];
  endfunction

  // Round-robin search from rr_q; grants are suppressed entirely during INIT.
  always_comb begin
    logic [31:0]      c;
    logic [PTR_W-1:0] cidx;
    c       = '0;
    cidx    = '0;
    elig    = bus.ch_rd_req | bus.ch_wr_req;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (state_q == ST_RUN) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        c    = (32'(rr_q) + i) % 32'(NUM_CH);
        cidx = c[PTR_W-1:0];
        if (!gnt_any && elig[cidx]) begin
          gnt_any = 1'b1;
          gnt_idx = cidx;
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign gnt_widx  = wrap_idx(bus.ch_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH]);
  assign gnt_wdata = bus.ch_wr_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  // Write wins when a channel holds both requests; the read stays pending.
  assign do_wr     = gnt_any & bus.ch_wr_req[gnt_idx];
  assign do_rd     = gnt_any & ~bus.ch_wr_req[gnt_idx] & bus.ch_rd_req[gnt_idx];

  always_comb begin
    logic [31:0] nxt;
    nxt     = (32'(gnt_idx) + 32'd1) % 32'(NUM_CH);
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = gnt_any ? nxt[PTR_W-1:0] : rr_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(MEM_DEPTH - 1)) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    pv_d[0]    = do_rd;
    ptag_d[0]  = gnt_idx;
    pdata_d[0] = mem_q[gnt_widx];
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      pv_d[i]    = pv_q[i-1];
      ptag_d[i]  = ptag_q[i-1];
      pdata_d[i] = pdata_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      rr_q    <= '0;
      pv_q    <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        ptag_q[i]  <= '0;
        pdata_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      pv_q    <= pv_d;
      ptag_q  <= ptag_d;
      pdata_q <= pdata_d;
    end
  end

  // Storage is not reset; the INIT sweep zero-fills it after every reset release.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) mem_q[cnt_q] <= '0;
    else if (do_wr)         mem_q[gnt_widx] <= gnt_wdata;
  end

  always_comb begin
    bus.rd_valid = '0;
    if (pv_q[RD_LATENCY-1]) bus.rd_valid[ptag_q[RD_LATENCY-1]] = 1'b1;
  end

  assign bus.rd_data   = pv_q[RD_LATENCY-1] ? pdata_q[RD_LATENCY-1] : '0;
  assign bus.ch_gnt    = gnt;
  assign bus.init_done = (state_q == ST_RUN);
endmodule
